// File: rtl/dmem_request_ctrl.sv
// Data-memory request controller: registers a read/write request and holds it
// until dhit, with halt lockout, flush abort and a wait-state watchdog.
module dmem_request_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            halt,
    input  logic            flush,
    input  logic            dREN,
    input  logic            dWEN,
    input  logic [AW-1:0]   daddr,
    input  logic [DW-1:0]   dstore,
    input  logic [DW/8-1:0] dbyte_en,
    output logic            dmREN,
    output logic            dmWEN,
    output logic [AW-1:0]   dmaddr,
    output logic [DW-1:0]   dmstore,
    output logic [DW/8-1:0] dmbyte_en,
    output logic            busy,
    output logic            done,
    output logic            derr,
    output logic            halted
);

    localparam int BW = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        HALTED
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   store_q, store_d;
    logic [BW-1:0]   ben_q, ben_d;
    logic            done_q, done_d;
    logic            derr_q, derr_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            store_q <= '0;
            ben_q   <= '0;
            done_q  <= 1'b0;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            ben_q   <= ben_d;
            done_q  <= done_d;
            derr_q  <= derr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        store_d = store_q;
        ben_d   = ben_q;
        done_d  = 1'b0;
        derr_d  = 1'b0;
        if (halt) begin
            state_d = HALTED;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ihit && dWEN) begin
                        state_d = WRITE;
                        cnt_d   = '0;
                        addr_d  = daddr;
                        store_d = dstore;
                        ben_d   = dbyte_en;
                    end else if (ihit && dREN) begin
                        state_d = READ;
                        cnt_d   = '0;
                        addr_d  = daddr;
                        ben_d   = '1;
                    end
                end
                READ, WRITE: begin
                    if (dhit) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (flush) begin
                        state_d = IDLE;
                    end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        derr_d  = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HALTED: state_d = HALTED;
                default: state_d = IDLE;
            endcase
        end
    end

    assign dmREN     = (state_q == READ);
    assign dmWEN     = (state_q == WRITE);
    assign busy      = dmREN | dmWEN;
    assign halted    = (state_q == HALTED);
    assign dmaddr    = addr_q;
    assign dmstore   = store_q;
    assign dmbyte_en = ben_q;
    assign done      = done_q;
    assign derr      = derr_q;

endmodule

// File: tb/tb_dmem_request_ctrl.sv
// Directed bench for dmem_request_ctrl with TIMEOUT=4: cycle-by-cycle vector
// table plus hand-written reset sequences.
module tb_dmem_request_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, halt, flush, dREN, dWEN;
    logic [31:0] daddr, dstore;
    logic [3:0]  dbyte_en;
    logic        dmREN, dmWEN, busy, done, derr, halted;
    logic [31:0] dmaddr, dmstore;
    logic [3:0]  dmbyte_en;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    dmem_request_ctrl #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .halt(halt),
        .flush(flush), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .dbyte_en(dbyte_en), .dmREN(dmREN), .dmWEN(dmWEN),
        .dmaddr(dmaddr), .dmstore(dmstore), .dmbyte_en(dmbyte_en),
        .busy(busy), .done(done), .derr(derr), .halted(halted)
    );

    typedef struct {
        logic        ih, dh, hl, fl, rn, wn;
        logic [31:0] a, s;
        logic [3:0]  b;
        logic        er, ew;
        logic [31:0] ea, es;
        logic [3:0]  eb;
        logic        ed, ee, eh;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ih, dh, hl, fl, rn, wn,
                       input logic [31:0] a, s, input logic [3:0] b,
                       input logic er, ew, input logic [31:0] ea, es,
                       input logic [3:0] eb, input logic ed, ee, eh);
        vec_t v;
        v.ih = ih; v.dh = dh; v.hl = hl; v.fl = fl; v.rn = rn; v.wn = wn;
        v.a = a; v.s = s; v.b = b;
        v.er = er; v.ew = ew; v.ea = ea; v.es = es; v.eb = eb;
        v.ed = ed; v.ee = ee; v.eh = eh;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic er, ew,
                           input logic [31:0] ea, es, input logic [3:0] eb,
                           input logic ed, ee, eh);
        chk("dmREN", idx, {31'b0, dmREN}, {31'b0, er});
        chk("dmWEN", idx, {31'b0, dmWEN}, {31'b0, ew});
        chk("busy", idx, {31'b0, busy}, {31'b0, er | ew});
        chk("dmaddr", idx, dmaddr, ea);
        chk("dmstore", idx, dmstore, es);
        chk("dmbyte_en", idx, {28'b0, dmbyte_en}, {28'b0, eb});
        chk("done", idx, {31'b0, done}, {31'b0, ed});
        chk("derr", idx, {31'b0, derr}, {31'b0, ee});
        chk("halted", idx, {31'b0, halted}, {31'b0, eh});
    endtask

    task automatic idle_in();
        ihit = 0; dhit = 0; halt = 0; flush = 0; dREN = 0; dWEN = 0;
        daddr = '0; dstore = '0; dbyte_en = '0;
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] CF = 32'hCAFEF00D;

    initial begin
        idle_in();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk_all(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;

        //   ih dh hl fl rn wn addr     store         ben   er ew eaddr    estore ebe  ed ee eh
        add(1, 0, 0, 0, 1, 0, 32'h100, 0,            4'h0, 1, 0, 32'h100, 0,  4'hF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0,            4'h0, 1, 0, 32'h100, 0,  4'hF, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,       0,            4'h0, 0, 0, 32'h100, 0,  4'hF, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0,            4'h0, 0, 0, 32'h100, 0,  4'hF, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 32'h200, DB,           4'h3, 0, 1, 32'h200, DB, 4'h3, 0, 0, 0);
        add(1, 0, 0, 0, 1, 1, 32'h300, 32'h11111111, 4'hF, 0, 1, 32'h200, DB, 4'h3, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,       0,            4'h0, 0, 0, 32'h200, DB, 4'h3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0,            4'h0, 0, 0, 32'h200, DB, 4'h3, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 32'h400, CF,           4'hC, 0, 1, 32'h400, CF, 4'hC, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,       0,            4'h0, 0, 0, 32'h400, CF, 4'hC, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 32'h500, 32'h12345678, 4'h1, 1, 0, 32'h500, CF, 4'hF, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0,       0,            4'h0, 0, 0, 32'h500, CF, 4'hF, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0,            4'h0, 0, 0, 32'h500, CF, 4'hF, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 32'h600, 0,            4'h0, 1, 0, 32'h600, CF, 4'hF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0,            4'h0, 1, 0, 32'h600, CF, 4'hF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0,            4'h0, 1, 0, 32'h600, CF, 4'hF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0,            4'h0, 1, 0, 32'h600, CF, 4'hF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0,            4'h0, 0, 0, 32'h600, CF, 4'hF, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0,            4'h0, 0, 0, 32'h600, CF, 4'hF, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 32'h700, 0,            4'h0, 1, 0, 32'h700, CF, 4'hF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0,            4'h0, 1, 0, 32'h700, CF, 4'hF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0,            4'h0, 1, 0, 32'h700, CF, 4'hF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0,            4'h0, 1, 0, 32'h700, CF, 4'hF, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,       0,            4'h0, 0, 0, 32'h700, CF, 4'hF, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,       0,            4'h0, 0, 0, 32'h700, CF, 4'hF, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 32'h800, 0,            4'h0, 1, 0, 32'h800, CF, 4'hF, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0, 32'h900, 0,            4'h0, 0, 0, 32'h800, CF, 4'hF, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0, 32'h900, 0,            4'h0, 1, 0, 32'h900, CF, 4'hF, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0,       0,            4'h0, 0, 0, 32'h900, CF, 4'hF, 0, 0, 1);
        add(1, 0, 0, 0, 1, 0, 32'hA00, 0,            4'h0, 0, 0, 32'h900, CF, 4'hF, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1, 32'hB00, DB,           4'h1, 0, 0, 32'h900, CF, 4'hF, 0, 0, 1);

        foreach (vecs[i]) begin
            ihit = vecs[i].ih; dhit = vecs[i].dh; halt = vecs[i].hl;
            flush = vecs[i].fl; dREN = vecs[i].rn; dWEN = vecs[i].wn;
            daddr = vecs[i].a; dstore = vecs[i].s; dbyte_en = vecs[i].b;
            @(posedge CLK);
            #1;
            chk_all(i + 1, vecs[i].er, vecs[i].ew, vecs[i].ea, vecs[i].es,
                    vecs[i].eb, vecs[i].ed, vecs[i].ee, vecs[i].eh);
        end

        // Reset leaves HALTED and clears the latched fields
        idle_in();
        nRST = 1'b0;
        #2;
        chk_all(100, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // Asynchronous reset while a write is outstanding
        ihit = 1; dWEN = 1; daddr = 32'hB00; dstore = 32'h55AA55AA;
        dbyte_en = 4'h5;
        @(posedge CLK);
        #1;
        chk_all(101, 0, 1, 32'hB00, 32'h55AA55AA, 4'h5, 0, 0, 0);
        idle_in();
        #2;
        nRST = 1'b0;
        #1;
        chk_all(102, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        chk_all(103, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
